cwru_tx_keyframer: RTL and testbench
====================================

# cwru_tx_keyframer

Parametrised key-triggered frame transmitter for the CWRU transceiver TX board. It debounces N active-low push-buttons, queues each press, and serialises one framed code word per press onto a GPIO line, in NRZ or Manchester line coding. It also shows the index of the last transmitted key on a 7-segment digit. It generalises the fixed 4-key TX path to any key count, payload width, bit rate and line code, and adds press queueing.

## Interface
- N_KEYS, 4, number of key channels (1..8)
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a key level (1 ms at 50 MHz)
- BIT_CYCLES, 2500, CLK cycles per transmitted bit; must be even and ≥2
- PREAMBLE_BITS, 8, length of the alternating preamble (≥1)
- PAYLOAD_W, 8, payload width in bits (≥3)
- CODE_BASE, 8'hA0, payload = CODE_BASE + key index, truncated to PAYLOAD_W
- MANCHESTER, 0, 0 = NRZ, 1 = Manchester

- CLK  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous, active-low reset
- KEY  in  N_KEYS  raw push-buttons, active-low, asynchronous to CLK
- TX_OUT  out  1  serial line
- TX_EN  out  1  high for every cycle of a frame
- BUSY  out  1  high whenever the FSM is not IDLE
- PENDING  out  N_KEYS  queued presses not yet started
- HEX0  out  7  active-low segments, {g,f,e,d,c,b,a}

## Operation
- Per key: 2-flop synchroniser (reset 1), then a debounce counter. The debounced level takes the new value only after DEBOUNCE_CYCLES consecutive samples that differ from it. Debounced level resets to 1.
- Press event: debounced 1→0 transition. It sets PENDING[i]. A press on a key that is already pending merges; no count is kept.
- FSM states: IDLE → LOAD → PREAMBLE → START → DATA → PARITY → STOP → IDLE.
- IDLE: if PENDING≠0, go to LOAD.
- LOAD (1 cycle): pick the lowest set PENDING index, clear that bit, latch the payload, update HEX0.
- Frame content, in order:
  - preamble of PREAMBLE_BITS bits, alternating, starting with 1
  - start bit 0
  - PAYLOAD_W data bits, LSB first
  - even-parity bit over the payload
  - stop bit 1
- NRZ: TX_OUT holds the bit value for BIT_CYCLES.
- Manchester: each bit is two halves of BIT_CYCLES/2. Bit 1 is low then high; bit 0 is high then low.
- Outside a frame: TX_OUT=1, TX_EN=0.
- HEX0 shows the hex digit of the key index (0..7) of the last frame started. After reset HEX0 is blank (7'h7F).
- Simultaneous events:
  - A press on key i in the same cycle LOAD clears PENDING[i]: the set wins, so PENDING[i] stays 1.
  - Presses on several keys in one cycle: all are set, then served lowest index first.

## Timing
- Reset values: TX_OUT=1, TX_EN=0, BUSY=0, PENDING=0, HEX0=7'h7F, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately to the reset values. A key still held after reset release debounces to 0 and counts as a new press.
- Latency from the debounced edge: PENDING[i] rises at clock edge t+1, BUSY rises at t+2 (LOAD), TX_EN and the first preamble bit start at t+3.
- Frame length: F = PREAMBLE_BITS + PAYLOAD_W + 3 bits. TX_EN is high for exactly F·BIT_CYCLES cycles.
- Back-to-back frames: after STOP, 1 IDLE cycle + 1 LOAD cycle, so TX_EN is low for exactly 2 cycles between frames. BUSY drops only during that single IDLE cycle.
- Bit counter and half-bit counter wrap at BIT_CYCLES−1 and BIT_CYCLES/2−1. There are no off-by-one bit stretches at state changes.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, BIT_CYCLES=4, PREAMBLE_BITS=4, PAYLOAD_W=8, CODE_BASE=8'hA0, 20 ns clock.
- Reset: assert RST_N=0 at any time → TX_OUT=1, TX_EN=0, BUSY=0, PENDING=0, HEX0=7'h7F.
- Single press: KEY=4'b1110 held 20 cycles, NRZ.
  - One frame with TX_EN high for 60 cycles.
  - Bit sequence 1,0,1,0 | 0 | 0,0,0,0,0,1,0,1 | 0 | 1, each bit held 4 cycles.
  - HEX0=7'h40.
- Glitch reject: KEY[1] low for 3 cycles → PENDING stays 0, no TX_EN.
- Simultaneous press: KEY[2] and KEY[1] fall in the same cycle → PENDING=4'b0110.
  - First frame carries A1 with parity 1, and HEX0=7'h79 during it.
  - TX_EN then goes low for exactly 2 cycles.
  - Second frame carries A2 with parity 1, and HEX0=7'h24 during it.
- Manchester: MANCHESTER=1, press KEY[3] → payload A3. Every bit is 2 cycles + 2 cycles: bit 1 is 0 then 1, bit 0 is 1 then 0. TX_EN is high for 60 cycles.
- Abort: drive RST_N low during the DATA state of a frame → reset values on the same edge, and no frame resumes after release while all keys are high.

Source files
------------

// File: rtl/cwru_tx_keyframer.sv
// Key-triggered frame transmitter: debounces active-low keys, queues presses and
// sends one preamble/start/data/parity/stop frame per press in NRZ or Manchester.
module cwru_tx_keyframer #(
  parameter int          N_KEYS          = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          BIT_CYCLES      = 2500,
  parameter int          PREAMBLE_BITS   = 8,
  parameter int          PAYLOAD_W       = 8,
  parameter int unsigned CODE_BASE       = 32'hA0,
  parameter bit          MANCHESTER      = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic              TX_OUT,
  output logic              TX_EN,
  output logic              BUSY,
  output logic [N_KEYS-1:0] PENDING,
  output logic [6:0]        HEX0
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BIT_W   = $clog2(BIT_CYCLES);
  localparam int HALF    = BIT_CYCLES / 2;
  localparam int IDX_MAX = (PREAMBLE_BITS > PAYLOAD_W) ? PREAMBLE_BITS : PAYLOAD_W;
  localparam int IDX_W   = (IDX_MAX > 2) ? $clog2(IDX_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREAMBLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic [6:0] seg7(input logic [2:0] d);
    case (d)
      3'd0:    seg7 = 7'h40;
      3'd1:    seg7 = 7'h79;
      3'd2:    seg7 = 7'h24;
      3'd3:    seg7 = 7'h30;
      3'd4:    seg7 = 7'h19;
      3'd5:    seg7 = 7'h12;
      3'd6:    seg7 = 7'h02;
      default: seg7 = 7'h78;
    endcase
  endfunction

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] deb_q, deb_d, deb_prev_q;
  logic [DEB_W-1:0]  deb_cnt_q [N_KEYS];
  logic [DEB_W-1:0]  deb_cnt_d [N_KEYS];
  logic [N_KEYS-1:0] press;

  state_t               state_q, state_d;
  logic [BIT_W-1:0]     bit_cyc_q, bit_cyc_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d, load_payload;
  logic                 parity_q, parity_d;
  logic [6:0]           hex_q, hex_d;
  logic [N_KEYS-1:0]    pending_q, pending_d, clear_mask;
  logic [2:0]           sel_idx;
  logic                 bit_end, cur_bit, frame_active, second_half;

  // The debounced level only flips after an unbroken run of differing samples.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_prev_q & ~deb_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= KEY;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 3'(i);
    end
  end

  assign load_payload = PAYLOAD_W'(CODE_BASE + 32'(sel_idx));
  assign bit_end      = (bit_cyc_q == BIT_W'(BIT_CYCLES - 1));

  // The payload shifts right once per data bit, so bit 0 is always the live bit.
  always_comb begin
    state_d    = state_q;
    bit_cyc_d  = bit_cyc_q;
    bit_idx_d  = bit_idx_q;
    payload_d  = payload_q;
    parity_d   = parity_q;
    hex_d      = hex_q;
    clear_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        clear_mask = N_KEYS'(1) << sel_idx;
        payload_d  = load_payload;
        parity_d   = ^load_payload;
        hex_d      = seg7(sel_idx);
        bit_cyc_d  = '0;
        bit_idx_d  = '0;
        state_d    = S_PREAMBLE;
      end
      default: begin
        bit_cyc_d = bit_end ? '0 : bit_cyc_q + 1'b1;
        if (bit_end) begin
          case (state_q)
            S_PREAMBLE: begin
              if (bit_idx_q == IDX_W'(PREAMBLE_BITS - 1)) begin
                bit_idx_d = '0;
                state_d   = S_START;
              end else begin
                bit_idx_d = bit_idx_q + 1'b1;
              end
            end
            S_START: state_d = S_DATA;
            S_DATA: begin
              payload_d = payload_q >> 1;
              if (bit_idx_q == IDX_W'(PAYLOAD_W - 1)) begin
                bit_idx_d = '0;
                state_d   = S_PARITY;
              end else begin
                bit_idx_d = bit_idx_q + 1'b1;
              end
            end
            S_PARITY: state_d = S_STOP;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // A fresh press in the LOAD cycle beats the clear, so it is never lost.
  assign pending_d = (pending_q & ~clear_mask) | press;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      bit_cyc_q <= '0;
      bit_idx_q <= '0;
      payload_q <= '0;
      parity_q  <= 1'b0;
      hex_q     <= 7'h7F;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cyc_q <= bit_cyc_d;
      bit_idx_q <= bit_idx_d;
      payload_q <= payload_d;
      parity_q  <= parity_d;
      hex_q     <= hex_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    cur_bit = 1'b1;
    case (state_q)
      S_PREAMBLE: cur_bit = ~bit_idx_q[0];
      S_START:    cur_bit = 1'b0;
      S_DATA:     cur_bit = payload_q[0];
      S_PARITY:   cur_bit = parity_q;
      default:    cur_bit = 1'b1;
    endcase
  end

  assign frame_active = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign second_half  = (bit_cyc_q >= BIT_W'(HALF));

  always_comb begin
    TX_OUT = 1'b1;
    if (frame_active) begin
      if (MANCHESTER) TX_OUT = second_half ? cur_bit : ~cur_bit;
      else            TX_OUT = cur_bit;
    end
  end

  assign TX_EN   = frame_active;
  assign BUSY    = (state_q != S_IDLE);
  assign PENDING = pending_q;
  assign HEX0    = hex_q;

endmodule

// File: tb/tb_cwru_tx_keyframer.sv
// Bench for cwru_tx_keyframer: an NRZ and a Manchester instance share keys and reset,
// a frame-level model is compared every cycle, and directed cases pin literal values.
module tb_cwru_tx_keyframer;

  localparam int NK     = 4;
  localparam int DEB    = 4;
  localparam int BC     = 4;
  localparam int PRE    = 4;
  localparam int PW     = 8;
  localparam int FBITS  = PRE + PW + 3;
  localparam int FCYC   = FBITS * BC;

  logic          clk;
  logic          rstN;
  logic [NK-1:0] key;

  logic          txOutN, txEnN, busyN;
  logic [NK-1:0] pendN;
  logic [6:0]    hexN;
  logic          txOutM, txEnM, busyM;
  logic [NK-1:0] pendM;
  logic [6:0]    hexM;

  int checks = 0;
  int errors = 0;

  cwru_tx_keyframer #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .BIT_CYCLES(BC), .PREAMBLE_BITS(PRE),
    .PAYLOAD_W(PW), .CODE_BASE(32'hA0), .MANCHESTER(1'b0)
  ) dutNrz (
    .CLK(clk), .RST_N(rstN), .KEY(key), .TX_OUT(txOutN), .TX_EN(txEnN),
    .BUSY(busyN), .PENDING(pendN), .HEX0(hexN)
  );

  cwru_tx_keyframer #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .BIT_CYCLES(BC), .PREAMBLE_BITS(PRE),
    .PAYLOAD_W(PW), .CODE_BASE(32'hA0), .MANCHESTER(1'b1)
  ) dutMan (
    .CLK(clk), .RST_N(rstN), .KEY(key), .TX_OUT(txOutM), .TX_EN(txEnM),
    .BUSY(busyM), .PENDING(pendM), .HEX0(hexM)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k, input int holdCycles);
    @(negedge clk);
    #2;
    key = k;
    repeat (holdCycles) @(posedge clk);
  endtask

  function automatic logic frameBit(input logic [PW-1:0] p, input int k);
    if (k < PRE)            return (k % 2) == 0;
    if (k == PRE)           return 1'b0;
    if (k < PRE + 1 + PW)   return p[k-PRE-1];
    if (k == PRE + 1 + PW)  return ^p;
    return 1'b1;
  endfunction

  function automatic logic [6:0] hexOf(input int d);
    logic [6:0] table7 [8];
    table7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    return table7[d];
  endfunction

  // Model: key levels pass a 2-sample delay and a run-length debouncer; a falling
  // debounced level queues the key; an idle line takes one cycle to notice the
  // queue and one more to load, then emits FCYC cycles of frame.
  logic [NK-1:0] mS1, mS2, mDeb, mDebPrev, mPending;
  int            mCnt [NK];
  int            mMode;
  int            mCyc;
  logic [PW-1:0] mPayload;
  logic [6:0]    mHex;

  initial begin
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        mS1 = '1; mS2 = '1; mDeb = '1; mDebPrev = '1; mPending = '0;
        for (int i = 0; i < NK; i++) mCnt[i] = 0;
        mMode = 0; mCyc = 0; mPayload = '0; mHex = 7'h7F;
      end else begin
        logic [NK-1:0] pressNow;
        logic [NK-1:0] clr;
        int            pick;
        pressNow = mDebPrev & ~mDeb;
        clr = '0;
        pick = 0;
        if (mMode == 0) begin
          if (mPending != 0) mMode = 1;
        end else if (mMode == 1) begin
          for (int i = NK - 1; i >= 0; i--) if (mPending[i]) pick = i;
          clr[pick] = 1'b1;
          mPayload = PW'(32'hA0 + pick);
          mHex = hexOf(pick);
          mMode = 2;
          mCyc = 0;
        end else begin
          mCyc++;
          if (mCyc == FCYC) mMode = 0;
        end
        mPending = (mPending & ~clr) | pressNow;
        mDebPrev = mDeb;
        for (int i = 0; i < NK; i++) begin
          if (mS2[i] != mDeb[i]) begin
            mCnt[i]++;
            if (mCnt[i] == DEB) begin
              mDeb[i] = mS2[i];
              mCnt[i] = 0;
            end
          end else begin
            mCnt[i] = 0;
          end
        end
        mS2 = mS1;
        mS1 = key;
      end
    end
  end

  initial begin
    forever begin
      logic       en, b, nrzE, manE, busyE;
      @(negedge clk);
      en    = (mMode == 2);
      b     = en ? frameBit(mPayload, mCyc / BC) : 1'b1;
      nrzE  = en ? b : 1'b1;
      manE  = en ? (((mCyc % BC) < (BC / 2)) ? ~b : b) : 1'b1;
      busyE = (mMode != 0);
      checkOutput("cycleNrz", 64'({txOutN, txEnN, busyN, pendN, hexN}),
                  64'({nrzE, en, busyE, mPending, mHex}));
      checkOutput("cycleMan", 64'({txOutM, txEnM, busyM, pendM, hexM}),
                  64'({manE, en, busyE, mPending, mHex}));
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "Nrz"}, 64'({txOutN, txEnN, busyN, pendN, hexN}), 64'({1'b1, 1'b0, 1'b0, 4'b0000, 7'h7F}));
    checkOutput({tag, "Man"}, 64'({txOutM, txEnM, busyM, pendM, hexM}), 64'({1'b1, 1'b0, 1'b0, 4'b0000, 7'h7F}));
  endtask

  task automatic captureFrame(output int len, output logic [FBITS-1:0] nrzBits,
                              output logic [2*FBITS-1:0] manBits, output logic [6:0] hexAt);
    int waitCnt;
    waitCnt = 0;
    len = 0;
    nrzBits = '0;
    manBits = '0;
    hexAt = 7'h00;
    while (!txEnN && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("txEnRise", 64'(txEnN), 64'(1'b1));
    while (txEnN && len < 200) begin
      if (len == 0) hexAt = hexN;
      if (len % BC == 0) nrzBits = {nrzBits[FBITS-2:0], txOutN};
      if (len % (BC / 2) == 0) manBits = {manBits[2*FBITS-2:0], txOutM};
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int                 len, gap, waitCnt;
    logic [FBITS-1:0]   nb;
    logic [2*FBITS-1:0] mb;
    logic [6:0]         hx;
    logic               saw;

    key  = '1;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkReset("reset");
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single press on key 0");
    fork
      begin
        applyStimulus(4'b1110, 20);
        applyStimulus(4'b1111, 1);
      end
      begin
        captureFrame(len, nb, mb, hx);
        checkOutput("singleLen", 64'(len), 64'(60));
        checkOutput("singleBits", 64'(nb), 64'(15'b101000000010101));
        checkOutput("singleHex", 64'(hx), 64'(7'h40));
      end
    join
    repeat (20) @(negedge clk);

    $display("[TB] glitch on key 1");
    saw = 1'b0;
    fork
      begin
        applyStimulus(4'b1101, 3);
        applyStimulus(4'b1111, 1);
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (txEnN || pendN != 0) saw = 1'b1;
        end
      end
    join
    checkOutput("glitchReject", 64'(saw), 64'(1'b0));

    $display("[TB] simultaneous press on keys 2 and 1");
    fork
      begin
        applyStimulus(4'b1001, 20);
        applyStimulus(4'b1111, 1);
      end
      begin
        waitCnt = 0;
        while (pendN == 0 && waitCnt < 100) begin
          @(negedge clk);
          waitCnt++;
        end
        checkOutput("pendingBoth", 64'(pendN), 64'(4'b0110));
        captureFrame(len, nb, mb, hx);
        checkOutput("firstLen", 64'(len), 64'(60));
        checkOutput("firstBits", 64'(nb), 64'(15'b101001000010111));
        checkOutput("firstHex", 64'(hx), 64'(7'h79));
        gap = 0;
        while (!txEnN && gap < 50) begin
          gap++;
          @(negedge clk);
        end
        checkOutput("gapCycles", 64'(gap), 64'(2));
        captureFrame(len, nb, mb, hx);
        checkOutput("secondLen", 64'(len), 64'(60));
        checkOutput("secondBits", 64'(nb), 64'(15'b101000100010111));
        checkOutput("secondHex", 64'(hx), 64'(7'h24));
      end
    join
    repeat (20) @(negedge clk);

    $display("[TB] manchester frame on key 3");
    fork
      begin
        applyStimulus(4'b0111, 20);
        applyStimulus(4'b1111, 1);
      end
      begin
        captureFrame(len, nb, mb, hx);
        checkOutput("manLen", 64'(len), 64'(60));
        checkOutput("manHalves", 64'(mb), 64'(30'b011001101001011010100110011001));
        checkOutput("manHex", 64'(hx), 64'(7'h30));
      end
    join
    repeat (20) @(negedge clk);

    $display("[TB] reset during data bits");
    applyStimulus(4'b1110, 0);
    waitCnt = 0;
    while (!txEnN && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("abortTxEnRise", 64'(txEnN), 64'(1'b1));
    repeat (24) @(negedge clk);
    #2;
    key  = '1;
    rstN = 1'b0;
    #1;
    checkReset("abort");
    repeat (3) @(negedge clk);
    #2;
    rstN = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (txEnN || busyN || pendN != 0) saw = 1'b1;
    end
    checkOutput("noResume", 64'(saw), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
